// File: rtl/a23_cache_flush_engine_if.sv
// CP15-side bundle for the cache flush engine: control inputs, tag RAM write port and status.
interface a23_cache_flush_engine_if #(
  parameter int unsigned LINE_ADDR_W = 8,
  parameter int unsigned WAYS        = 4
);
  logic                   i_cache_enable;
  logic                   i_cache_flush;
  logic [31:0]            i_cacheable_area;
  logic [31:0]            i_address;
  logic                   o_cacheable;
  logic                   o_stall;
  logic                   o_tag_wen;
  logic [LINE_ADDR_W-1:0] o_tag_waddr;
  logic [WAYS-1:0]        o_tag_wway;
  logic                   o_flush_done;
  logic [15:0]            o_flush_count;

  modport master (
    output i_cache_enable, i_cache_flush, i_cacheable_area, i_address,
    input  o_cacheable, o_stall, o_tag_wen, o_tag_waddr, o_tag_wway,
           o_flush_done, o_flush_count
  );

  modport slave (
    input  i_cache_enable, i_cache_flush, i_cacheable_area, i_address,
    output o_cacheable, o_stall, o_tag_wen, o_tag_waddr, o_tag_wway,
           o_flush_done, o_flush_count
  );
endinterface

// File: rtl/a23_cache_flush_engine.sv
// Walks every tag line clearing all ways after reset or a CP15 flush strobe, stalling the core meanwhile.
// Optional completed-walk counter enabled by defining A23_FLUSH_COUNT_EN.
module a23_cache_flush_engine #(
  parameter int unsigned LINE_ADDR_W = 8,
  parameter int unsigned WAYS        = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  a23_cache_flush_engine_if.slave  bus
);
  localparam int unsigned CNT_W = 16;
  localparam logic [LINE_ADDR_W-1:0] LAST_LINE = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_WALK, ST_DONE} state_t;

  state_t                 state_q, state_d;
  logic [LINE_ADDR_W-1:0] line_q, line_d;
  logic                   stall_q, stall_d;
  logic                   wen_q, wen_d;
  logic [LINE_ADDR_W-1:0] waddr_q, waddr_d;
  logic [WAYS-1:0]        wway_q, wway_d;
  logic                   done_q, done_d;

  // Next state plus next registered outputs, decoded from the next state
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_cache_flush) begin
          state_d = ST_WALK;
          line_d  = '0;
        end
      end
      ST_WALK: begin
        if (bus.i_cache_flush) begin
          line_d = '0;
        end else if (line_q == LAST_LINE) begin
          state_d = ST_DONE;
          line_d  = '0;
        end else begin
          line_d = line_q + LINE_ADDR_W'(1);
        end
      end
      ST_DONE: begin
        state_d = bus.i_cache_flush ? ST_WALK : ST_IDLE;
        line_d  = '0;
      end
      default: begin
        state_d = ST_WALK;
        line_d  = '0;
      end
    endcase

    stall_d = (state_d != ST_IDLE);
    wen_d   = (state_d == ST_WALK);
    waddr_d = wen_d ? line_d : '0;
    wway_d  = {WAYS{wen_d}};
    done_d  = (state_d == ST_DONE);
  end

  // Reset lands in WALK at line 0 so tags are cleared from power-up
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_WALK;
      line_q  <= '0;
      stall_q <= 1'b1;
      wen_q   <= 1'b1;
      waddr_q <= '0;
      wway_q  <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      stall_q <= stall_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wway_q  <= wway_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_stall      = stall_q;
  assign bus.o_tag_wen    = wen_q;
  assign bus.o_tag_waddr  = waddr_q;
  assign bus.o_tag_wway   = wway_q;
  assign bus.o_flush_done = done_q;

`ifdef A23_FLUSH_COUNT_EN
  logic [CNT_W-1:0] fcount_q;

  // Saturating count of completed walks, bumped as each DONE cycle ends
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fcount_q <= '0;
    end else if (state_q == ST_DONE && fcount_q != '1) begin
      fcount_q <= fcount_q + CNT_W'(1);
    end
  end

  assign bus.o_flush_count = fcount_q;
`else
  assign bus.o_flush_count = CNT_W'(0);
`endif

  // 2MB regions from bits 25:21; upper bits ignored so the map repeats every 64MB
  assign bus.o_cacheable = bus.i_cache_enable & ~stall_q
                         & bus.i_cacheable_area[bus.i_address[25:21]];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_address[31:26], bus.i_address[20:0]};
endmodule

// File: tb/tb_a23_cache_flush_engine.sv
// Scoreboard bench for a23_cache_flush_engine: per-cycle expectations queued by the driver, checked by a negedge monitor.
module tb_a23_cache_flush_engine;
  localparam int unsigned LINE_ADDR_W = 8;
  localparam int unsigned WAYS        = 4;
  localparam int unsigned NLINES      = 1 << LINE_ADDR_W;
`ifdef A23_FLUSH_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  typedef struct {
    logic        stall;
    logic        wen;
    logic [7:0]  waddr;
    logic [3:0]  wway;
    logic        done;
    logic [15:0] count;
    logic        cacheable;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  a23_cache_flush_engine_if #(.LINE_ADDR_W(LINE_ADDR_W), .WAYS(WAYS)) bus ();

  a23_cache_flush_engine #(.LINE_ADDR_W(LINE_ADDR_W), .WAYS(WAYS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  rec_t        pend_q[$];
  rec_t        exp_q[$];
  rec_t        mon_e;
  logic [15:0] cnt_model;
  int          n_vec = 0;
  int          n_err = 0;

  // Remaining cycles of the walk the model believes is in flight: every line, then one done cycle
  task automatic start_walk();
    rec_t r;
    pend_q.delete();
    for (int k = 0; k < int'(NLINES); k++) begin
      r = '{stall: 1'b1, wen: 1'b1, waddr: 8'(k), wway: 4'hF, done: 1'b0, count: 16'h0, cacheable: 1'b0};
      pend_q.push_back(r);
    end
    r = '{stall: 1'b1, wen: 1'b0, waddr: 8'h0, wway: 4'h0, done: 1'b1, count: 16'h0, cacheable: 1'b0};
    pend_q.push_back(r);
  endtask

  task automatic step(input logic flush, input logic rst_v, input logic en,
                      input logic [31:0] area, input logic [31:0] addr);
    rec_t r;
    if (pend_q.size() > 0) r = pend_q.pop_front();
    else r = '{stall: 1'b0, wen: 1'b0, waddr: 8'h0, wway: 4'h0, done: 1'b0, count: 16'h0, cacheable: 1'b0};
    r.count = COUNT_EN ? cnt_model : 16'h0;
    if (r.done && cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
    rst                  = rst_v;
    bus.i_cache_flush    = flush;
    bus.i_cache_enable   = en;
    bus.i_cacheable_area = area;
    bus.i_address        = addr;
    r.cacheable = en && !r.stall && (((area >> ((addr / 32'h0020_0000) % 32)) & 32'd1) == 32'd1);
    exp_q.push_back(r);
    if (rst_v || flush) start_walk();
    if (rst_v) cnt_model = 16'h0;
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_step(input logic flush, input logic rst_v);
    step(flush, rst_v, ($urandom_range(0, 3) != 0), $urandom, $urandom);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      chk("stall",       32'(bus.o_stall),       32'(mon_e.stall));
      chk("tag_wen",     32'(bus.o_tag_wen),     32'(mon_e.wen));
      chk("tag_waddr",   32'(bus.o_tag_waddr),   32'(mon_e.waddr));
      chk("tag_wway",    32'(bus.o_tag_wway),    32'(mon_e.wway));
      chk("flush_done",  32'(bus.o_flush_done),  32'(mon_e.done));
      chk("flush_count", 32'(bus.o_flush_count), 32'(mon_e.count));
      chk("cacheable",   32'(bus.o_cacheable),   32'(mon_e.cacheable));
    end
  end

  initial begin
    rst                  = 1'b1;
    bus.i_cache_flush    = 1'b0;
    bus.i_cache_enable   = 1'b0;
    bus.i_cacheable_area = 32'h0;
    bus.i_address        = 32'h0;
    cnt_model            = 16'h0;
    @(posedge clk);
    #1;
    start_walk();

    // Reset walk runs to completion then idles
    repeat (NLINES + 4) rnd_step(1'b0, 1'b0);

    // Flush from idle
    rnd_step(1'b1, 1'b0);
    repeat (NLINES + 10) rnd_step(1'b0, 1'b0);

    // Re-strobe while line 0x64 is being written
    rnd_step(1'b1, 1'b0);
    repeat (100) rnd_step(1'b0, 1'b0);
    rnd_step(1'b1, 1'b0);
    repeat (NLINES + 10) rnd_step(1'b0, 1'b0);

    // Cacheability in idle, then during a walk
    step(1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'h0040_0000);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'h0020_0000);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'h0440_0000);
    step(1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'h0040_0000);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0004, 32'h0040_0000);
    repeat (5) step(1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'h0040_0000);
    repeat (NLINES + 10) rnd_step(1'b0, 1'b0);

    // Reset while line 0x80 is being written
    rnd_step(1'b1, 1'b0);
    repeat (128) rnd_step(1'b0, 1'b0);
    rnd_step(1'b0, 1'b1);
    repeat (NLINES + 10) rnd_step(1'b0, 1'b0);

    // Strobe exactly in the DONE cycle
    rnd_step(1'b1, 1'b0);
    repeat (NLINES) rnd_step(1'b0, 1'b0);
    rnd_step(1'b1, 1'b0);
    repeat (NLINES + 10) rnd_step(1'b0, 1'b0);

    // Random strobes and resets
    repeat (4000) rnd_step(($urandom_range(0, 199) == 0), ($urandom_range(0, 599) == 0));
    repeat (NLINES + 4) rnd_step(1'b0, 1'b0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/a23_cache_flush_engine.md
Name: a23_cache_flush_engine

Overview:
- Sits directly downstream of the CP15 co-processor block. Consumes its cache-enable, cache-flush strobe and cacheable-area outputs.
- On a flush strobe, and after every reset, it walks every cache line index and clears the valid bits in all ways of the tag RAM.
- Stalls the core for the duration of the walk.
- Also decodes per-access cacheability from the 32-bit cacheable-area map, one bit per 2MB region.

Parameters:
LINE_ADDR_W, 8, line index width; number of lines = 2**LINE_ADDR_W
WAYS, 4, number of cache ways cleared per line write

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous active-high reset
i_cache_enable  input  1  cache on/off, from CP15 cache-control bit 0
i_cache_flush  input  1  single-cycle flush strobe from CP15 (write to CP15 reg 1)
i_cacheable_area  input  32  bit n = 2MB region n cacheable
i_address  input  32  current core access address
o_cacheable  output  1  access at i_address may be cached
o_stall  output  1  core stall request; high while flush walk active
o_tag_wen  output  1  tag RAM write enable
o_tag_waddr  output  LINE_ADDR_W  tag RAM line index being cleared
o_tag_wway  output  WAYS  way mask for the tag write; all ones during a walk
o_flush_done  output  1  one-cycle pulse on completion of a walk
o_flush_count  output  16  completed-walk counter (see Optional Feature)

Behaviour:
- Clock and reset: one clock, i_clk, all flops on its rising edge. Reset i_rst is synchronous, active-high.
- Reset state:
  - FSM enters WALK with line counter = 0, so tags are cleared from power-up.
  - o_stall = 1, o_tag_wen = 1, o_tag_waddr = 0, o_flush_done = 0, o_flush_count = 0.
- States:
  - IDLE: o_stall = 0, o_tag_wen = 0, o_tag_waddr = 0, o_tag_wway = 0. i_cache_flush = 1 -> WALK with counter = 0.
  - WALK:
    - o_stall = 1, o_tag_wen = 1, o_tag_waddr = counter, o_tag_wway = all ones.
    - Counter increments by 1 each cycle.
    - When counter = 2**LINE_ADDR_W - 1 and the write is issued -> DONE.
  - DONE: o_flush_done = 1 for exactly this cycle, o_stall = 1, o_tag_wen = 0. Next state is IDLE.
- Latency: a strobe sampled in cycle N gives the first tag write (line 0) in cycle N+1 and the last line in cycle N+2**LINE_ADDR_W. DONE falls in cycle N+2**LINE_ADDR_W+1; o_stall drops in the following cycle.
- Flush strobe while in WALK: counter restarts at 0 next cycle; no done pulse for the aborted walk.
- Flush strobe while in DONE: no done-pulse suppression for this cycle; next state is WALK with counter = 0 instead of IDLE.
- i_cache_enable changes during WALK: no effect on the walk. The walk always completes.
- Reset asserted mid-walk: counter returns to 0 and the walk restarts. o_flush_count is cleared.
- Counter wrap: counter width is exactly LINE_ADDR_W bits. No write beyond the last line is ever issued.
- Cacheability (combinational):
  - o_cacheable = i_cache_enable & !o_stall & i_cacheable_area[i_address[25:21]].
  - Address bits 31:26 are ignored, so the map aliases every 64MB.

Optional Feature:
Macro: A23_FLUSH_COUNT_EN
- Defined: 16-bit counter increments in each DONE cycle. It saturates at 0xFFFF, is cleared by reset, and is driven on o_flush_count.
- Not defined: no counter logic; o_flush_count tied to 16'h0000.

Test Plan (LINE_ADDR_W = 8, WAYS = 4):
1. Reset for 1 cycle, then release:
   - o_tag_wen high for 256 consecutive cycles with o_tag_waddr 0x00..0xFF and o_tag_wway = 4'hF.
   - o_flush_done pulses once in the next cycle; o_stall low the cycle after.
2. From IDLE, strobe i_cache_flush in cycle N:
   - First write to line 0 in N+1, line 0xFF in N+256, o_flush_done in N+257.
   - With the macro defined, o_flush_count increments 1 -> 2 counting the reset walk.
3. Re-strobe i_cache_flush when o_tag_waddr = 0x64:
   - Next cycle o_tag_waddr = 0x00.
   - Total 0x65 + 256 writes, exactly one o_flush_done pulse.
4. Cacheability with i_cache_enable = 1, i_cacheable_area = 32'h0000_0004, in IDLE:
   - Address 0x0040_0000 -> o_cacheable = 1.
   - Address 0x0020_0000 -> 0.
   - Address 0x0440_0000 -> 1 (alias).
   - i_cache_enable = 0 -> 0.
   - Any address during WALK -> 0.
5. Assert i_rst at o_tag_waddr = 0x80:
   - Next cycle o_tag_waddr = 0x00 and o_flush_done stays low.
   - o_flush_count = 0, then a full 256-line walk follows.
6. Strobe i_cache_flush exactly in the DONE cycle:
   - o_flush_done still pulses, and the next cycle is WALK at line 0 with o_stall held high throughout (no IDLE gap).
